// File: rtl/hash_msg_loader.sv
// hash_msg_loader: byte-stream front end for the Ascon Hash core.
// Packs message words MSB-first, sequences the core's reset/start,
// and hands the captured digest downstream under a valid/ack handshake.
module hash_msg_loader #(
    parameter int y = 40,
    parameter int l = 256,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [y-1:0] msg_out,
    output logic         core_rst,
    output logic         core_start,
    input  logic         core_ready,
    input  logic [l-1:0] core_hash,
    output logic [l-1:0] hash_out,
    output logic         hash_valid,
    input  logic         hash_ack
);

    localparam int NW = y / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

    // A message that is not a whole number of words cannot be packed.
    generate
        if ((y % W) != 0 || y < W) begin : g_bad_width
            $error("hash_msg_loader: y must be a non-zero multiple of W");
        end
    endgenerate

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        START,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] word_cnt;
    logic [y-1:0]  shifted;

    // Next message value after shifting one word in at the LSB end; a
    // single-word message simply takes the word.
    generate
        if (NW == 1) begin : g_one_word
            assign shifted = in_data;
        end else begin : g_multi_word
            assign shifted = {msg_out[y-W-1:0], in_data};
        end
    endgenerate

    // Main sequencer: load words, clear and start the core, capture the digest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            word_cnt   <= '0;
            msg_out    <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        msg_out <= shifted;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= CLEAR;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    core_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (core_ready) begin
                        hash_out   <= core_hash;
                        hash_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (hash_ack) begin
                        hash_valid <= 1'b0;
                        state      <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // Ready and the core reset are pure state decodes; core_rst also follows
    // the system reset so the sticky core ready drops immediately.
    assign in_ready = (state == LOAD);
    assign core_rst = rst | (state == CLEAR);

endmodule

// File: doc/hash_msg_loader.md
Name: hash_msg_loader

Overview:
Upstream front-end for the Ascon Hash core.
- Accepts the message as a byte stream over a valid/ready handshake and packs it MSB-first into the core's fixed y-bit message bus.
- Sequences the core's reset/start controls, then captures the finished digest and presents it downstream under a valid/ack handshake.
- Lets the sticky-ready core run back-to-back jobs without a system reset.

Parameters:
y, 40, message length in bits; must be a multiple of W (elaboration error otherwise)
l, 256, digest width in bits; matches core l
W, 8, input word width in bits
NW, y/W, derived localparam: number of input words per message

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_data  in  W  message word, first word is most significant
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts in_data this cycle
msg_out  out  y  packed message to core message input; stable from START until the next LOAD acceptance
core_rst  out  1  reset to core: rst OR (state==CLEAR), combinational decode
core_start  out  1  start to core, single-cycle pulse
core_ready  in  1  core ready (sticky high until core reset)
core_hash  in  l  core digest, valid while core_ready=1
hash_out  out  l  registered digest
hash_valid  out  1  hash_out valid
hash_ack  in  1  downstream consumed hash_out

Behaviour:
- Reset values: state=LOAD, word counter=0, msg_out=0, hash_out=0, hash_valid=0, core_start=0. in_ready=1 after reset, since it decodes LOAD. core_rst=1 while rst is high.
- States: LOAD, CLEAR, START, BUSY, DONE.
- LOAD:
  - in_ready=1. Each cycle with in_valid=1, shift: msg_out <= {msg_out[y-W-1:0], in_data}; counter++.
  - On acceptance of word NW-1: counter <= 0, go to CLEAR. The first accepted word ends in msg_out[y-1 -: W].
- CLEAR: core_rst=1 for exactly one cycle (clears sticky core ready) -> START.
- START: core_start=1 for exactly one cycle -> BUSY.
- BUSY:
  - Wait for core_ready=1. On that edge: hash_out <= core_hash; go to DONE.
  - hash_valid=1 from the next cycle.
  - core_ready is ignored in every other state.
- DONE:
  - hash_valid=1; hash_out held.
  - On hash_ack=1: hash_valid <= 0, go to LOAD (in_ready=1 the following cycle).
- Latency: last word accepted at edge N; core_rst high in cycle N+1; core_start high in cycle N+2; BUSY from N+3. Digest latched one edge after core_ready is observed.
- in_ready=0 outside LOAD. in_valid outside LOAD is ignored: no shift, no count.
- hash_ack outside DONE is ignored.
- hash_ack held constantly high: DONE lasts exactly one cycle.
- msg_out must not change in CLEAR, START, BUSY or DONE. The core reads it combinationally during absorb.
- Reset mid-operation, any state:
  - Return to LOAD; discard partial words and pending digest; hash_valid=0 the next cycle.
  - core_rst asserted throughout rst.
- NW=1 (y=W): a single accepted word goes directly to CLEAR.

Test Plan:
- y=40, W=8, words 0x11,0x22,0x33,0x44,0x55 with in_valid constant -> msg_out=40'h1122334455 after 5th accept; core_rst high 1 cycle, core_start high 1 cycle the next cycle; in_ready=0 from CLEAR onward.
- Same words with in_valid low for 3 cycles between 0x22 and 0x33 -> identical msg_out, counter holds, no early CLEAR.
- Core model raises core_ready 40 cycles after core_start with core_hash=256'hA5A5...A5 -> hash_out=256'hA5..A5 and hash_valid=1 one cycle later; hash_ack held low 10 cycles -> hash_valid and hash_out stay stable.
- Back-to-back: second message 0xDE,0xAD,0xBE,0xEF,0x01 with core_ready still high from job 1 -> core_rst pulse drops ready, no capture before the new core_ready rise; hash_out updates to the second digest only.
- rst asserted in BUSY and again after 3 words of LOAD -> state LOAD, counter 0, hash_valid=0, core_rst=1 during rst; subsequent full message packs correctly from scratch.
- in_valid=1 and hash_ack=1 pulsed in CLEAR/START/BUSY -> no msg_out change, no state change.
